// File: rtl/bht_pkg.sv
// Shared types and constants for the branch history table controller.
// Optional write-to-lookup forwarding is enabled with BHT_BYPASS_EN.
package bht_pkg;

    localparam int BHT_ADDR_WIDTH = 5;
    localparam int BHT_CNT_WIDTH  = 2;

    localparam logic [BHT_CNT_WIDTH-1:0] WEAK_NT = 2'b01;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } bht_state_e;

    typedef struct packed {
        logic [BHT_ADDR_WIDTH-1:0] addr;
        logic                      taken;
    } upd_entry_t;

endpackage

// File: rtl/bht_upd_fifo.sv
// Resolved-branch update queue for the BHT controller.
// Clear wins over pop; a push in the clearing cycle lands in slot 0.
module bht_upd_fifo #(
    parameter int W     = 6,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [PW:0]   wr_ptr;
    logic [PW:0]   rd_ptr;
    logic [PW-1:0] wr_idx;
    logic [W-1:0]  mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= push ? PTR_ONE : '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_comb begin
        wr_idx = wr_ptr[PW-1:0];
        if (clear)
            wr_idx = '0;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_idx] <= din;
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign head  = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/bht_ctrl.sv
// Branch history table controller: lookup, queued updates, flush sweep.
// Define BHT_BYPASS_EN to forward same-cycle writes to the lookup port.
module bht_ctrl
    import bht_pkg::*;
#(
    parameter int ENTRY_NUM  = 32,
    parameter int ADDR_WIDTH = BHT_ADDR_WIDTH,
    parameter int CNT_WIDTH  = BHT_CNT_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] lk_addr,
    output logic [CNT_WIDTH-1:0]  lk_cnt,
    output logic                  lk_taken,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [ADDR_WIDTH-1:0] upd_addr,
    input  logic                  upd_taken,
    input  logic                  flush_req,
    output logic                  flush_busy,
    output logic [ADDR_WIDTH-1:0] ram_r0_addr,
    output logic [ADDR_WIDTH-1:0] ram_r1_addr,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    input  logic [CNT_WIDTH-1:0]  ram_r0_data,
    input  logic [CNT_WIDTH-1:0]  ram_r1_data,
    output logic                  ram_we,
    output logic [CNT_WIDTH-1:0]  ram_wdata
);

    localparam logic [ADDR_WIDTH-1:0] IDX_LAST =
        ADDR_WIDTH'(ENTRY_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE = ADDR_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX = '1;

    bht_state_e            state;
    bht_state_e            state_nxt;
    logic [ADDR_WIDTH-1:0] sweep_idx;
    logic [ADDR_WIDTH-1:0] idx_nxt;

    upd_entry_t            push_entry;
    upd_entry_t            head;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_WIDTH-1:0]  sat_cnt;

    assign upd_ready        = !fifo_full && reset_n;
    assign fifo_push        = upd_valid && upd_ready;
    assign push_entry.addr  = upd_addr;
    assign push_entry.taken = upd_taken;

    bht_upd_fifo #(
        .W     ($bits(upd_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .clear   (flush_req),
        .din     (push_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head)
    );

    assign ram_r0_addr = lk_addr;
    assign ram_r1_addr = head.addr;

    always_comb begin
        sat_cnt = ram_r1_data;
        unique case (1'b1)
            head.taken && (ram_r1_data != CNT_MAX):
                sat_cnt = ram_r1_data + CNT_ONE;
            !head.taken && (ram_r1_data != '0):
                sat_cnt = ram_r1_data - CNT_ONE;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            sweep_idx <= '0;
        end else begin
            state     <= state_nxt;
            sweep_idx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = sweep_idx;
        fifo_pop  = 1'b0;
        ram_we    = 1'b0;
        ram_waddr = head.addr;
        ram_wdata = sat_cnt;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    ram_we   = 1'b1;
                end
                if (flush_req) begin
                    state_nxt = SWEEP;
                    idx_nxt   = '0;
                end
            end
            SWEEP: begin
                ram_we    = 1'b1;
                ram_waddr = sweep_idx;
                ram_wdata = CNT_WIDTH'(WEAK_NT);
                if (flush_req) begin
                    idx_nxt = '0;
                end else if (sweep_idx == IDX_LAST) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = sweep_idx + IDX_ONE;
                end
            end
            default: ;
        endcase
    end

    assign flush_busy = (state == SWEEP);

`ifdef BHT_BYPASS_EN
    always_comb begin
        lk_cnt = ram_r0_data;
        if (ram_we && (ram_waddr == lk_addr))
            lk_cnt = ram_wdata;
    end
`else
    assign lk_cnt = ram_r0_data;
`endif

    assign lk_taken = lk_cnt[CNT_WIDTH-1];

endmodule

// File: tb/tb_bht_ctrl.sv
// Directed testbench for bht_ctrl with a behavioural 2R1W counter RAM.
// Expected values are hand-derived; BHT_BYPASS_EN selects lookup expectations.
module tb_bht_ctrl;

    logic       clk;
    logic       reset_n;
    logic [4:0] lk_addr;
    logic [1:0] lk_cnt;
    logic       lk_taken;
    logic       upd_valid;
    logic       upd_ready;
    logic [4:0] upd_addr;
    logic       upd_taken;
    logic       flush_req;
    logic       flush_busy;
    logic [4:0] ram_r0_addr;
    logic [4:0] ram_r1_addr;
    logic [4:0] ram_waddr;
    logic [1:0] ram_r0_data;
    logic [1:0] ram_r1_data;
    logic       ram_we;
    logic [1:0] ram_wdata;

    int checks = 0;
    int errors = 0;

    logic [1:0] mem [32];

    bht_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .lk_addr     (lk_addr),
        .lk_cnt      (lk_cnt),
        .lk_taken    (lk_taken),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_addr    (upd_addr),
        .upd_taken   (upd_taken),
        .flush_req   (flush_req),
        .flush_busy  (flush_busy),
        .ram_r0_addr (ram_r0_addr),
        .ram_r1_addr (ram_r1_addr),
        .ram_waddr   (ram_waddr),
        .ram_r0_data (ram_r0_data),
        .ram_r1_data (ram_r1_data),
        .ram_we      (ram_we),
        .ram_wdata   (ram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++)
                mem[i] <= 2'b00;
        end else if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    assign ram_r0_data = mem[ram_r0_addr];
    assign ram_r1_data = mem[ram_r1_addr];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wr(input string tag,
                          input logic [4:0] a,
                          input logic [1:0] d);
        chk({tag, "_we"}, 32'(ram_we), 32'd1);
        chk({tag, "_waddr"}, 32'(ram_waddr), 32'(a));
        chk({tag, "_wdata"}, 32'(ram_wdata), 32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] exp_sat [4];
        logic [4:0] t_addr [4];
        logic       t_tkn [4];
        logic [1:0] t_exp [4];
        exp_sat = '{2'd1, 2'd2, 2'd3, 2'd3};
        t_addr  = '{5'd12, 5'd13, 5'd14, 5'd15};
        t_tkn   = '{1'b1, 1'b0, 1'b1, 1'b1};
        t_exp   = '{2'd2, 2'd0, 2'd2, 2'd2};

        reset_n   = 1'b0;
        lk_addr   = 5'd0;
        upd_valid = 1'b0;
        upd_addr  = 5'd0;
        upd_taken = 1'b0;
        flush_req = 1'b0;
        tick();
        tick();
        tick();
        #1;
        chk("rst_ready", 32'(upd_ready), 32'd0);
        chk("rst_busy", 32'(flush_busy), 32'd0);
        chk("rst_we", 32'(ram_we), 32'd0);

        reset_n = 1'b1;
        lk_addr = 5'd3;
        #1;
        chk("rel_ready", 32'(upd_ready), 32'd1);
        chk("rel_busy", 32'(flush_busy), 32'd0);
        chk("lk3_cnt", 32'(lk_cnt), 32'd0);
        chk("lk3_taken", 32'(lk_taken), 32'd0);

        upd_valid = 1'b1;
        upd_addr  = 5'd5;
        upd_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3)
                upd_valid = 1'b0;
            #1;
            chk_wr("sat5", 5'd5, exp_sat[i]);
        end
        tick();
        lk_addr = 5'd5;
        #1;
        chk("sat5_idle_we", 32'(ram_we), 32'd0);
        chk("lk5_cnt", 32'(lk_cnt), 32'd3);
        chk("lk5_taken", 32'(lk_taken), 32'd1);

        upd_valid = 1'b1;
        upd_addr  = 5'd0;
        upd_taken = 1'b0;
        tick();
        upd_valid = 1'b0;
        #1;
        chk_wr("nt0", 5'd0, 2'd0);
        tick();
        #1;
        chk("nt0_after_we", 32'(ram_we), 32'd0);

        upd_valid = 1'b1;
        upd_addr  = 5'd7;
        upd_taken = 1'b1;
        lk_addr   = 5'd7;
        tick();
        upd_valid = 1'b0;
        #1;
        chk_wr("byp7", 5'd7, 2'd1);
`ifdef BHT_BYPASS_EN
        chk("byp7_lk_wcyc", 32'(lk_cnt), 32'd1);
`else
        chk("byp7_lk_wcyc", 32'(lk_cnt), 32'd0);
`endif
        tick();
        #1;
        chk("byp7_lk_next", 32'(lk_cnt), 32'd1);

        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        #1;
        chk("sw1_busy", 32'(flush_busy), 32'd1);
        chk_wr("sw1_i0", 5'd0, 2'd1);
        for (int i = 1; i <= 3; i++) begin
            upd_valid = 1'b1;
            upd_addr  = 5'(i);
            upd_taken = 1'b1;
            tick();
        end
        upd_valid = 1'b0;
        #1;
        chk_wr("sw1_i3", 5'd3, 2'd1);
        chk("sw1_ready3", 32'(upd_ready), 32'd1);

        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0)
                tick();
            upd_valid = (k == 10);
            upd_addr  = 5'd9;
            upd_taken = 1'b1;
            #1;
            chk("sw2_busy", 32'(flush_busy), 32'd1);
            chk_wr("sw2", 5'(k), 2'd1);
        end
        tick();
        upd_valid = 1'b0;
        lk_addr   = 5'd20;
        #1;
        chk("sw2_end_busy", 32'(flush_busy), 32'd0);
        chk_wr("sw2_upd9", 5'd9, 2'd2);
        chk("sw2_lk20", 32'(lk_cnt), 32'd1);
        tick();
        #1;
        chk("sw2_discard_we", 32'(ram_we), 32'd0);

        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0)
                tick();
            upd_valid = 1'b1;
            upd_addr  = t_addr[i];
            upd_taken = t_tkn[i];
            #1;
            chk("sw3_ready_pre", 32'(upd_ready), 32'd1);
        end
        tick();
        upd_valid = 1'b0;
        #1;
        chk("sw3_ready_full", 32'(upd_ready), 32'd0);
        chk("sw3_busy", 32'(flush_busy), 32'd1);
        for (int k = 5; k < 32; k++)
            tick();
        #1;
        chk("sw3_last_busy", 32'(flush_busy), 32'd1);
        chk_wr("sw3_i31", 5'd31, 2'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("sw3_drain_busy", 32'(flush_busy), 32'd0);
            chk_wr("sw3_drain", t_addr[i], t_exp[i]);
            chk("sw3_drain_ready", 32'(upd_ready),
                32'(i != 0));
        end
        tick();
        #1;
        chk("sw3_drain_done", 32'(ram_we), 32'd0);

        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        upd_valid = 1'b1;
        upd_addr  = 5'd4;
        upd_taken = 1'b1;
        tick();
        upd_valid = 1'b0;
        for (int k = 2; k <= 10; k++)
            tick();
        #1;
        chk_wr("rst_sw_i10", 5'd10, 2'd1);
        reset_n = 1'b0;
        tick();
        #1;
        chk("rst_sw_busy", 32'(flush_busy), 32'd0);
        chk("rst_sw_we", 32'(ram_we), 32'd0);
        chk("rst_sw_ready", 32'(upd_ready), 32'd0);
        reset_n = 1'b1;
        lk_addr = 5'd5;
        #1;
        chk("rst_rel_ready", 32'(upd_ready), 32'd1);
        chk("rst_rel_we", 32'(ram_we), 32'd0);
        chk("rst_rel_lk5", 32'(lk_cnt), 32'd0);
        tick();
        #1;
        chk("rst_lost_we", 32'(ram_we), 32'd0);
        chk("rst_lost_busy", 32'(flush_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
